seg_display: RTL and testbench

- Memory-mapped 7-segment output device on the CPU bridge; the output-side counterpart of the key-input device.
- CPU writes a 32-bit word as 8 hex nibbles. The block time-multiplexes them onto an active-low common-anode display.
- Readback of both registers is provided on the bus.

---
 rtl/seg_pkg.sv | 24 ++
 rtl/seg_hex_decoder.sv | 13 +
 rtl/seg_display.sv | 110 +++++++++++
 tb/tb_seg_display.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the 7-segment output device.
//   - bus address decode (DATA / CTRL)
//   - CTRL field positions and reset value
//   - hex-to-segment table (active-low, bit7 = dp, bits6..0 = g..a)
package seg_pkg;

  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_CTRL = 1'b1;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_RESTART   = 1;
  localparam int CTRL_BLANK_LSB = 8;
  localparam int CTRL_BLANK_MSB = 15;

  localparam logic [31:0] CTRL_RESET = 32'h0000_0001;
  localparam logic [7:0]  SEG_BLANK  = 8'hFF;

  // Entry n is the code for nibble n; dp (bit7) is 1 in every entry.
  localparam logic [15:0][7:0] HEX_SEG_TBL = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/seg_hex_decoder.sv
// seg_hex_decoder: combinational nibble -> active-low segment code.
//   nibble : 4-bit hex value
//   code   : 8-bit active-low code {dp, g..a}
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] code
);

  assign code = HEX_SEG_TBL[nibble];

endmodule

// File: rtl/seg_display.sv
// seg_display: memory-mapped, time-multiplexed 7-segment driver.
//   Parameters : SCAN_DIV (cycles per digit, >=2), DIGITS (1..8)
//   clk, reset : system clock, synchronous active-high reset
//   we, addr   : bus write strobe, register select (0 DATA, 1 CTRL)
//   wdata      : bus write data
//   rdata      : combinational readback of the selected register
//   seg_sel    : active-low digit enables, bit i shows nibble i
//   seg_code   : active-low segments {dp, g..a}
// Optional build macro SEG_LEADING_ZERO_BLANK_EN: darken leading zero
// digits (digit 0 is always shown).
module seg_display
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DIGITS   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic        addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  seg_sel,
  output logic [7:0]  seg_code
);

  localparam int              CNT_W   = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [2:0]      IDX_MAX = 3'(DIGITS - 1);

  logic [31:0]      data_q;
  logic             en_q;
  logic [7:0]       blank_q;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;

  logic [7:0][3:0]  nib;
  logic [7:0]       dec_code;
  logic             lit;
  logic             wr_ctrl;
  logic             restart;

  assign nib     = data_q;
  assign wr_ctrl = we && (addr == ADDR_CTRL);
  assign restart = wr_ctrl && wdata[CTRL_RESTART];

  seg_hex_decoder u_dec (
    .nibble (nib[idx]),
    .code   (dec_code)
  );

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // lz_dark[i]: nibble i and every higher scanned nibble are zero.
  logic [7:0] lz_dark;
  for (genvar i = 0; i < 8; i++) begin : g_lz
    if (i == 0 || i >= DIGITS) begin : g_off
      assign lz_dark[i] = 1'b0;
    end else begin : g_on
      assign lz_dark[i] = (data_q[4*DIGITS-1:4*i] == '0);
    end
  end
  assign lit = en_q & ~blank_q[idx] & ~lz_dark[idx];
`else
  assign lit = en_q & ~blank_q[idx];
`endif

  always_comb begin
    rdata = data_q;
    if (addr == ADDR_CTRL) begin
      rdata                                = '0;
      rdata[CTRL_EN]                       = en_q;
      rdata[CTRL_BLANK_MSB:CTRL_BLANK_LSB] = blank_q;
    end
  end

  // Outputs are computed from the pre-edge state, so a register write at
  // edge N shows up on the pins at edge N+1.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= '0;
      en_q     <= CTRL_RESET[CTRL_EN];
      blank_q  <= CTRL_RESET[CTRL_BLANK_MSB:CTRL_BLANK_LSB];
      cnt      <= '0;
      idx      <= '0;
      seg_sel  <= SEG_BLANK;
      seg_code <= SEG_BLANK;
    end else begin
      seg_sel  <= lit ? ~(8'b1 << idx) : SEG_BLANK;
      seg_code <= lit ? dec_code : SEG_BLANK;

      if (we && (addr == ADDR_DATA)) data_q <= wdata;
      if (wr_ctrl) begin
        en_q    <= wdata[CTRL_EN];
        blank_q <= wdata[CTRL_BLANK_MSB:CTRL_BLANK_LSB];
      end

      // RESTART wins over a wrap landing on the same edge.
      if (restart) begin
        cnt <= '0;
        idx <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt <= '0;
        idx <= (idx == IDX_MAX) ? 3'd0 : idx + 3'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_display.sv
// tb_seg_display: randomized + directed bench for seg_display with a
// time-based reference model (digit = (ticks since restart / SCAN_DIV)
// mod DIGITS).
module tb_seg_display;

  localparam int SCAN_DIV = 4;
  localparam int DIGITS   = 8;

  logic        clk = 1'b0;
  logic        reset, we, addr;
  logic [31:0] wdata, rdata;
  logic [7:0]  seg_sel, seg_code;

  seg_display #(.SCAN_DIV(SCAN_DIV), .DIGITS(DIGITS)) dut (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .seg_sel  (seg_sel),
    .seg_code (seg_code)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference model state
  logic [7:0]  tbl [16];
  logic [31:0] m_data;
  logic        m_en;
  logic [7:0]  m_blank;
  int          pos;
  logic [7:0]  exp_sel, exp_code;
  bit          armed = 0;

  initial begin
    tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  end

  function automatic logic [31:0] m_rd(input logic a);
    return a ? {16'h0, m_blank, 7'h0, m_en} : m_data;
  endfunction

  always @(posedge clk) begin
    int  d;
    bit  dark;
    if (reset) begin
      m_data = 0; m_en = 1; m_blank = 0; pos = 0;
      exp_sel = 8'hFF; exp_code = 8'hFF;
    end else begin
      d    = (pos / SCAN_DIV) % DIGITS;
      dark = !m_en || m_blank[d];
`ifdef SEG_LEADING_ZERO_BLANK_EN
      begin
        longint msk;
        msk = (DIGITS == 8) ? 64'hFFFF_FFFF : ((64'd1 << (4*DIGITS)) - 1);
        if (d > 0 && ((longint'(m_data) & msk) >> (4*d)) == 0) dark = 1;
      end
`endif
      exp_sel  = dark ? 8'hFF : 8'(~(32'd1 << d));
      exp_code = dark ? 8'hFF : tbl[(m_data >> (4*d)) & 32'hF];
      pos++;
      if (we) begin
        if (addr) begin
          m_en    = wdata[0];
          m_blank = wdata[15:8];
          if (wdata[1]) pos = 0;
        end else begin
          m_data = wdata;
        end
      end
    end
    armed = 1;
  end

  // Drive one cycle of inputs, check rdata for them, then check the pins
  // on the following negedge.
  task automatic step(input logic r, input logic w, input logic a, input logic [31:0] d);
    reset = r; we = w; addr = a; wdata = d;
    #1;
    if (armed) chk(a ? "rd_ctrl" : "rd_data", rdata, m_rd(a));
    @(posedge clk);
    @(negedge clk);
    chk("seg_sel", seg_sel, exp_sel);
    chk("seg_code", seg_code, exp_code);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'($urandom), 32'h0);
  endtask

  initial begin
    bit hit;
    // 1: reset hold, including a write attempt that must be ignored
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("rst_sel", seg_sel, 8'hFF);
    chk("rst_code", seg_code, 8'hFF);
    addr = 1'b0; #1 chk("rst_rd_data", rdata, 32'h0);
    addr = 1'b1; #1 chk("rst_rd_ctrl", rdata, 32'h1);

    // 2: full scan of 0x7654_3210 including wrap
    step(1'b0, 1'b1, 1'b0, 32'h7654_3210);
    idle(70);

    // 3: blank digit 1
    step(1'b0, 1'b1, 1'b1, 32'h0000_0201);
    addr = 1'b1; #1 chk("rd_ctrl_201", rdata, 32'h0000_0201);
    idle(40);

    // 4: RESTART on the exact wrap cycle (away from digit 0)
    step(1'b0, 1'b1, 1'b1, 32'h1);
    hit = 0;
    for (int k = 0; k < 64 && !hit; k++) begin
      if (pos % SCAN_DIV == SCAN_DIV-1 && (pos / SCAN_DIV) % DIGITS == 3) hit = 1;
      else step(1'b0, 1'b0, 1'b0, 32'h0);
    end
    chk("wrap_found", 32'(hit), 32'd1);
    step(1'b0, 1'b1, 1'b1, 32'h0000_0003);
    addr = 1'b1; #1 chk("restart_rd0", rdata[1], 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("restart_sel", seg_sel, 8'hFE);
    idle(10);

    // 5: disable then re-enable
    step(1'b0, 1'b1, 1'b1, 32'h0);
    idle(10);
    step(1'b0, 1'b1, 1'b1, 32'h1);
    idle(10);

    // 6: leading-zero patterns (also plain display in the default build)
    step(1'b0, 1'b1, 1'b0, 32'h0);
    idle(40);
    step(1'b0, 1'b1, 1'b0, 32'h0001_0000);
    idle(40);
    step(1'b0, 1'b1, 1'b0, 32'h0000_00A5);
    idle(40);

    // random traffic
    for (int k = 0; k < 2000; k++) begin
      logic [31:0] d;
      logic        a;
      a = 1'($urandom);
      if (a) d = {16'($urandom), ($urandom % 3 == 0) ? 8'($urandom) : 8'h0,
                  6'($urandom), ($urandom % 4 == 0), ($urandom % 8 != 0)};
      else   d = $urandom >> (4 * $urandom_range(0, 7));
      step(($urandom % 150) == 0, ($urandom % 12) == 0, a, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
